// File: rtl/seven_seg_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment driver.
//   SEG_0..SEG_9, SEG_DASH, SEG_BLANK : segment patterns {a,b,c,d,e,f,g},
//                                       active-high, MSB = a
//   SEG_OFF_N                         : active-low "all segments dark"
//   idx_width()                       : width of the digit index for a digit count
package seven_seg_pkg;

  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b0011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1110011;
  localparam logic [6:0] SEG_DASH  = 7'b0000001;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [6:0] SEG_OFF_N = 7'h7F;

  // Index width for a digit count; never narrower than one bit.
  function automatic int idx_width(input int digits);
    if (digits <= 1) begin
      return 1;
    end else begin
      return $clog2(digits);
    end
  endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// Combinational BCD-to-seven-segment decoder.
//   bcd   : 4-bit code; 0-9 digits, 10 dash, 11-15 blank
//   seg_n : segments {a,b,c,d,e,f,g}, active-low, MSB = a
module seven_seg_decoder
  import seven_seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg_n
);

  logic [6:0] seg_s;

  // Look up the active-high pattern for the code.
  always_comb begin
    seg_s = SEG_BLANK;
    case (bcd)
      4'd0:    seg_s = SEG_0;
      4'd1:    seg_s = SEG_1;
      4'd2:    seg_s = SEG_2;
      4'd3:    seg_s = SEG_3;
      4'd4:    seg_s = SEG_4;
      4'd5:    seg_s = SEG_5;
      4'd6:    seg_s = SEG_6;
      4'd7:    seg_s = SEG_7;
      4'd8:    seg_s = SEG_8;
      4'd9:    seg_s = SEG_9;
      4'd10:   seg_s = SEG_DASH;
      default: seg_s = SEG_BLANK;
    endcase
  end

  assign seg_n = ~seg_s;

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed scan driver for a common-anode seven-segment display.
//   clk, rst   : system clock, asynchronous active-high reset
//   load       : strobe capturing bcd_in / dp_in / blink_mask into the shadow
//   bcd_in     : one nibble per digit, digit 0 rightmost
//   dp_in      : decimal point per digit (active-high)
//   blink_mask : 1 = digit blinks
//   digit_en   : live per-digit enable
//   blank_lz   : live leading-zero blanking enable
//   an_n       : anode select, active-low, one-hot-low or all-high
//   seg_n      : segments {a..g}, active-low
//   dp_n       : decimal point, active-low
//   frame_done : one-cycle pulse when the last digit's slot starts
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int DIGITS       = 8,
  parameter int CLK_DIV      = 100000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blink_mask,
  input  logic [DIGITS-1:0]     digit_en,
  input  logic                  blank_lz,
  output logic [DIGITS-1:0]     an_n,
  output logic [6:0]            seg_n,
  output logic                  dp_n,
  output logic                  frame_done
);

  localparam int IW = idx_width(DIGITS);
  localparam int PW = $clog2(CLK_DIV);
  localparam int BW = (BLINK_FRAMES <= 1) ? 1 : $clog2(BLINK_FRAMES);

  localparam logic [IW-1:0] LAST_IDX   = IW'(DIGITS - 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  logic [PW-1:0]         presc_r;
  logic [IW-1:0]         idx_r;
  logic [BW-1:0]         blink_cnt_r;
  logic                  blink_phase_r;
  logic [4*DIGITS-1:0]   bcd_sh_r;
  logic [DIGITS-1:0]     dp_sh_r;
  logic [DIGITS-1:0]     blink_sh_r;

  logic                  tick_s;
  logic                  wrap_s;
  logic [3:0]            nib_s;
  logic [6:0]            dec_seg_n_s;
  logic [DIGITS-1:0]     lz_s;
  logic                  zero_run_s;
  logic                  blank_s;
  logic                  hide_s;
  logic [DIGITS-1:0]     one_hot_s;
  logic [DIGITS-1:0]     an_nxt_s;
  logic [6:0]            seg_nxt_s;
  logic                  dp_nxt_s;

  assign tick_s    = (presc_r == PRESC_LAST);
  assign wrap_s    = tick_s && (idx_r == LAST_IDX);
  assign nib_s     = bcd_sh_r[4*idx_r +: 4];
  assign one_hot_s = {{(DIGITS-1){1'b0}}, 1'b1} << idx_r;

  seven_seg_decoder u_dec (
    .bcd   (nib_s),
    .seg_n (dec_seg_n_s)
  );

  // lz_s[k] is set when nibbles k..DIGITS-1 are all zero; scanned from the top.
  always_comb begin
    zero_run_s = 1'b1;
    lz_s       = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_run_s = zero_run_s & (bcd_sh_r[4*k +: 4] == 4'h0);
      lz_s[k]    = zero_run_s;
    end
  end

  // Digit 0 always shows its value, even when the whole display is zero.
  assign blank_s = blank_lz && lz_s[idx_r] && (idx_r != {IW{1'b0}});
  assign hide_s  = blink_phase_r && blink_sh_r[idx_r];

  // Build the pattern for the digit about to be driven; priority is
  // disable > blink-off > leading-zero blank > decoded value.
  always_comb begin
    an_nxt_s  = {DIGITS{1'b1}};
    seg_nxt_s = SEG_OFF_N;
    dp_nxt_s  = 1'b1;
    if (digit_en[idx_r]) begin
      an_nxt_s = ~one_hot_s;
      if (hide_s) begin
        seg_nxt_s = SEG_OFF_N;
        dp_nxt_s  = 1'b1;
      end else if (blank_s) begin
        // A blanked digit still shows its decimal point.
        seg_nxt_s = SEG_OFF_N;
        dp_nxt_s  = ~dp_sh_r[idx_r];
      end else begin
        seg_nxt_s = dec_seg_n_s;
        dp_nxt_s  = ~dp_sh_r[idx_r];
      end
    end else begin
      an_nxt_s  = {DIGITS{1'b1}};
      seg_nxt_s = SEG_OFF_N;
      dp_nxt_s  = 1'b1;
    end
  end

  // Slot prescaler: wraps after CLK_DIV cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_r <= '0;
    end else if (tick_s) begin
      presc_r <= '0;
    end else begin
      presc_r <= presc_r + PW'(1);
    end
  end

  // Digit index advances once per slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_r <= '0;
    end else if (wrap_s) begin
      idx_r <= '0;
    end else if (tick_s) begin
      idx_r <= idx_r + IW'(1);
    end
  end

  // Blink phase flips after every BLINK_FRAMES completed frames.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt_r   <= '0;
      blink_phase_r <= 1'b0;
    end else if (wrap_s) begin
      if (blink_cnt_r == BLINK_LAST) begin
        blink_cnt_r   <= '0;
        blink_phase_r <= ~blink_phase_r;
      end else begin
        blink_cnt_r   <= blink_cnt_r + BW'(1);
      end
    end
  end

  // Shadow copy of the display data; a tick on the same edge still
  // reads the old contents because the output path samples the registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd_sh_r   <= {DIGITS{4'hF}};
      dp_sh_r    <= '0;
      blink_sh_r <= '0;
    end else if (load) begin
      bcd_sh_r   <= bcd_in;
      dp_sh_r    <= dp_in;
      blink_sh_r <= blink_mask;
    end
  end

  // Registered display outputs, updated only at slot boundaries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_n       <= {DIGITS{1'b1}};
      seg_n      <= SEG_OFF_N;
      dp_n       <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= wrap_s;
      if (tick_s) begin
        an_n  <= an_nxt_s;
        seg_n <= seg_nxt_s;
        dp_n  <= dp_nxt_s;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Scoreboard bench: stimulus pushes hand-computed slot expectations,
// a monitor pops one per slot edge (every CLK_DIV clocks after reset release).
module tb_seven_seg_scan_driver;

  localparam int DIGITS = 4;
  localparam int CLK_DIV = 4;
  localparam int BLINK_FRAMES = 2;

  logic        clk;
  logic        rst;
  logic        load;
  logic [15:0] bcd_in;
  logic [3:0]  dp_in;
  logic [3:0]  blink_mask;
  logic [3:0]  digit_en;
  logic        blank_lz;
  logic [3:0]  an_n;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic        frame_done;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  seven_seg_scan_driver #(
    .DIGITS       (DIGITS),
    .CLK_DIV      (CLK_DIV),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .bcd_in     (bcd_in),
    .dp_in      (dp_in),
    .blink_mask (blink_mask),
    .digit_en   (digit_en),
    .blank_lz   (blank_lz),
    .an_n       (an_n),
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push(input logic [3:0] an, input logic [6:0] seg, input logic dp, input logic fd);
    exp_t e;
    e.an = an; e.seg = seg; e.dp = dp; e.fd = fd;
    exp_q.push_back(e);
  endtask

  // Monitor: slot edges are every CLK_DIV-th posedge after release.
  initial begin
    int edge_cnt;
    exp_t e;
    edge_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        edge_cnt = 0;
      end else begin
        edge_cnt++;
        if (edge_cnt % CLK_DIV == 0) begin
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("slot_out", {3'b000, an_n, seg_n, dp_n, frame_done},
                {3'b000, e.an, e.seg, e.dp, e.fd});
          end
        end else begin
          chk("frame_done_idle", {15'h0, frame_done}, 16'h0000);
        end
      end
    end
  end

  // Reset, check inactive outputs, then release with a load on the first edge.
  task automatic start(input logic [15:0] bcd, input logic [3:0] dp, input logic [3:0] bm,
                       input logic [3:0] en, input logic lz);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("reset_out", {3'b000, an_n, seg_n, dp_n, frame_done}, {3'b000, 4'hF, 7'h7F, 1'b1, 1'b0});
    @(negedge clk);
    @(negedge clk);
    bcd_in = bcd; dp_in = dp; blink_mask = bm; digit_en = en; blank_lz = lz;
    load = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 16'(exp_q.size()), 16'h0000);
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; bcd_in = 16'h0000; dp_in = 4'h0;
    blink_mask = 4'h0; digit_en = 4'hF; blank_lz = 1'b0;
    #1;
    chk("reset_initial", {3'b000, an_n, seg_n, dp_n, frame_done}, {3'b000, 4'hF, 7'h7F, 1'b1, 1'b0});

    // Basic scan of 1234 with DP on digit 2, two frames.
    start(16'h1234, 4'b0100, 4'b0000, 4'b1111, 1'b0);
    for (int f = 0; f < 2; f++) begin
      push(4'b1110, 7'h4C, 1'b1, 1'b0);
      push(4'b1101, 7'h06, 1'b1, 1'b0);
      push(4'b1011, 7'h12, 1'b0, 1'b0);
      push(4'b0111, 7'h4F, 1'b1, 1'b1);
    end
    drain();

    // Leading-zero blanking of 0007; DP on blanked digit 3 still lit.
    start(16'h0007, 4'b1000, 4'b0000, 4'b1111, 1'b1);
    push(4'b1110, 7'h0F, 1'b1, 1'b0);
    push(4'b1101, 7'h7F, 1'b1, 1'b0);
    push(4'b1011, 7'h7F, 1'b1, 1'b0);
    push(4'b0111, 7'h7F, 1'b0, 1'b1);
    drain();

    // Dash on digit 0, upper digits blank.
    start(16'h000A, 4'b0000, 4'b0000, 4'b1111, 1'b1);
    push(4'b1110, 7'h7E, 1'b1, 1'b0);
    push(4'b1101, 7'h7F, 1'b1, 1'b0);
    push(4'b1011, 7'h7F, 1'b1, 1'b0);
    push(4'b0111, 7'h7F, 1'b1, 1'b1);
    drain();

    // Interior zero of 0105 is not blanked; only digit 3 is.
    start(16'h0105, 4'b0000, 4'b0000, 4'b1111, 1'b1);
    push(4'b1110, 7'h24, 1'b1, 1'b0);
    push(4'b1101, 7'h01, 1'b1, 1'b0);
    push(4'b1011, 7'h4F, 1'b1, 1'b0);
    push(4'b0111, 7'h7F, 1'b1, 1'b1);
    drain();

    // All zeros: digit 0 still shows 0.
    start(16'h0000, 4'b0000, 4'b0000, 4'b1111, 1'b1);
    push(4'b1110, 7'h01, 1'b1, 1'b0);
    push(4'b1101, 7'h7F, 1'b1, 1'b0);
    push(4'b1011, 7'h7F, 1'b1, 1'b0);
    push(4'b0111, 7'h7F, 1'b1, 1'b1);
    drain();

    // Digit 2 disabled; decimal point on digit 2 must not show.
    start(16'h1234, 4'b0100, 4'b0000, 4'b1011, 1'b0);
    for (int f = 0; f < 2; f++) begin
      push(4'b1110, 7'h4C, 1'b1, 1'b0);
      push(4'b1101, 7'h06, 1'b1, 1'b0);
      push(4'b1111, 7'h7F, 1'b1, 1'b0);
      push(4'b0111, 7'h4F, 1'b1, 1'b1);
    end
    drain();

    // Blink digit 0: visible frames 0,1; dark frames 2,3; visible frame 4.
    start(16'h1234, 4'b0001, 4'b0001, 4'b1111, 1'b0);
    for (int f = 0; f < 5; f++) begin
      if (f == 2 || f == 3) push(4'b1110, 7'h7F, 1'b1, 1'b0);
      else                  push(4'b1110, 7'h4C, 1'b0, 1'b0);
      push(4'b1101, 7'h06, 1'b1, 1'b0);
      push(4'b1011, 7'h12, 1'b1, 1'b0);
      push(4'b0111, 7'h4F, 1'b1, 1'b1);
    end
    drain();

    // Load coincident with the second tick, then reset mid-frame.
    start(16'h1234, 4'b0000, 4'b0000, 4'b1111, 1'b0);
    push(4'b1110, 7'h4C, 1'b1, 1'b0);
    push(4'b1101, 7'h06, 1'b1, 1'b0);
    push(4'b1011, 7'h60, 1'b1, 1'b0);
    repeat (6) @(negedge clk);
    bcd_in = 16'h5678;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_abort_drained", 16'(exp_q.size()), 16'h0000);
    rst = 1'b1;
    #1;
    chk("abort_out", {3'b000, an_n, seg_n, dp_n, frame_done}, {3'b000, 4'hF, 7'h7F, 1'b1, 1'b0});
    repeat (2) @(negedge clk);
    chk("abort_hold", {3'b000, an_n, seg_n, dp_n, frame_done}, {3'b000, 4'hF, 7'h7F, 1'b1, 1'b0});
    rst = 1'b0;
    // Shadow was reset to blank codes: anodes scan from digit 0, segments dark.
    push(4'b1110, 7'h7F, 1'b1, 1'b0);
    push(4'b1101, 7'h7F, 1'b1, 1'b0);
    push(4'b1011, 7'h7F, 1'b1, 1'b0);
    push(4'b0111, 7'h7F, 1'b1, 1'b1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seven_seg_scan_driver.md
SEVEN_SEG_SCAN_DRIVER -- requirements
Module: seven_seg_scan_driver

Interface
REQ-001 Parameter DIGITS, default 8: number of multiplexed digits, legal range 2..16.
REQ-002 Parameter CLK_DIV, default 100000: clk cycles per digit slot, minimum 2.
REQ-003 Parameter BLINK_FRAMES, default 64: full frames per blink half-period, minimum 1.
REQ-004 The design SHALL use one clock and an asynchronous, active-high reset.
REQ-005 clk  in  1  system clock; all state rises on posedge clk.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 load  in  1  single-cycle strobe; captures bcd_in, dp_in and blink_mask into the shadow register.
REQ-008 bcd_in  in  4*DIGITS  nibble k = digit k; digit 0 is rightmost.
REQ-009 dp_in  in  DIGITS  decimal point per digit, active-high.
REQ-010 blink_mask  in  DIGITS  1 = digit blinks.
REQ-011 digit_en  in  DIGITS  1 = digit enabled (live, not shadowed).
REQ-012 blank_lz  in  1  1 = leading-zero blanking on (live).
REQ-013 an_n  out  DIGITS  anode select, active-low, one-hot-low or all-high.
REQ-014 seg_n  out  7  segments {a,b,c,d,e,f,g}, MSB = a, active-low.
REQ-015 dp_n  out  1  decimal point, active-low.
REQ-016 frame_done  out  1  one-cycle pulse when the digit DIGITS-1 slot starts.

Function
REQ-017 Prescaler counts 0..CLK_DIV-1 and wraps; tick is asserted when prescaler = CLK_DIV-1.
REQ-018 On each tick edge, outputs SHALL be registered for digit idx, and idx SHALL then advance, wrapping from DIGITS-1 to 0.
REQ-019 Output latency: an_n, seg_n and dp_n change on the clk edge at which tick is high, and hold until the next tick.
REQ-020 Decode: 0-9 standard patterns (6 = 0011111, 9 = 1110011); 10 = dash (0000001); 11-15 = blank; the result is then inverted.
REQ-021 Disabled digit (digit_en[idx] = 0): an_n = all 1, seg_n = 7'h7F, dp_n = 1.
REQ-022 Leading-zero blanking: with blank_lz = 1, digit k > 0 is blanked when nibbles k..DIGITS-1 are all 0.
REQ-023 Digit 0 is never leading-zero blanked.
REQ-024 A blanked digit keeps its anode active, drives seg_n = 7'h7F, and passes its DP through.
REQ-025 Blink: blink_phase toggles every BLINK_FRAMES completed frames; while blink_phase = 1, digits with a set blink_mask bit drive seg_n = 7'h7F and dp_n = 1.
REQ-026 A frame completes on the tick at which idx wraps from DIGITS-1 to 0.
REQ-027 load and tick on the same edge: the tick uses the pre-load shadow; the new data appears from the next tick.
REQ-028 load with no tick updates only the shadow; outputs are unchanged until the next tick.
REQ-029 frame_done SHALL be high exactly one clk cycle, on the edge at which digit DIGITS-1 is driven.
REQ-030 digit_en and blank_lz are sampled at the tick edge.

Reset
REQ-031 While rst is high: prescaler = 0, idx = 0, blink counter = 0, blink_phase = 0.
REQ-032 While rst is high: shadow nibbles = 4'hF (blank), shadow DP = 0, shadow blink_mask = 0.
REQ-033 While rst is high: an_n = all 1, seg_n = 7'h7F, dp_n = 1, frame_done = 0.
REQ-034 Reset asserted mid-frame SHALL abort the scan immediately, with no completion pulse.
REQ-035 The first tick after reset release drives digit 0.

Structure
REQ-036 Package seven_seg_pkg SHALL hold the segment pattern constants (SEG_0..SEG_9, SEG_DASH, SEG_BLANK) and the width function for idx (clog2 of DIGITS).
REQ-037 Sub-module seven_seg_decoder SHALL be the combinational 4-bit BCD to 7-bit active-low pattern decoder, instantiated once on the selected nibble.

Verification (DIGITS=4, CLK_DIV=4, BLINK_FRAMES=2)
REQ-038 Reset, release, load bcd_in=16'h1234, dp_in=4'b0100 -> anodes scan 1110,1101,1011,0111 every 4 clk; digit 2 shows 2 with dp_n=0.
REQ-039 bcd_in=16'h0007, blank_lz=1 -> digits 3,2,1 seg_n=7'h7F with anodes active; digit 0 shows 7 (seg_n=7'b0001111).
REQ-040 bcd_in=16'h000A, blank_lz=1 -> digit 0 shows the dash (seg_n=7'b1111110); digits 3..1 are blank.
REQ-041 digit_en=4'b1011 -> an_n stays all 1 during the digit-2 slot; frame_done pulses once per 16 clk.
REQ-042 blink_mask=4'b0001 -> digit 0 is visible for 2 frames, then blank for 2 frames, repeating.
REQ-043 load coincident with tick, then rst pulsed mid-frame -> old data shown for that slot; after reset all outputs are inactive and the scan restarts at digit 0.
